// File: rtl/fetch_if.sv
// Instruction-fetch stage signal bundle: hazard/redirect controls, the
// InstructionMemory port and the IF/ID pipeline register outputs.
interface fetch_if;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] ImemInstruction;
    logic [31:0] ImemAddress;
    logic [31:0] IfIdInstruction;
    logic [31:0] IfIdPCPlus4;
    logic        IfIdValid;
    logic [31:0] FetchCount;

    modport master (
        output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, ImemInstruction,
        input  ImemAddress, IfIdInstruction, IfIdPCPlus4, IfIdValid, FetchCount
    );

    modport slave (
        input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, ImemInstruction,
        output ImemAddress, IfIdInstruction, IfIdPCPlus4, IfIdValid, FetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC select (jump > branch > stall > +4),
// IF/ID register with squash-on-redirect, and a delivered-instruction counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic   Clk,
    input  logic   Rst,
    fetch_if.slave fif
);
    typedef enum logic {ST_RESET, ST_RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic        redirect, squash, load;
    logic        unused_tgt_bits;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = fif.Jump | fif.BranchTaken;
    assign squash   = redirect | fif.Flush;
    assign load     = !squash && !fif.Stall;

    // Redirect targets are word-aligned by dropping the low two bits.
    assign unused_tgt_bits = ^{fif.JumpTarget[1:0], fif.BranchTarget[1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    // Flush does not redirect: the PC still advances unless stalled.
    always_comb begin
        pc_d = pc_plus4;
        if (fif.Jump)             pc_d = {fif.JumpTarget[31:2], 2'b00};
        else if (fif.BranchTaken) pc_d = {fif.BranchTarget[31:2], 2'b00};
        else if (fif.Stall)       pc_d = pc_q;
    end

    always_comb begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (squash) begin
            instr_d = 32'h0;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = fif.ImemInstruction;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign fif.ImemAddress     = pc_q;
    assign fif.IfIdInstruction = instr_q;
    assign fif.IfIdPCPlus4     = pcp4_q;
    assign fif.IfIdValid       = valid_q && (state_q == ST_RUN);
    assign fif.FetchCount      = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns word = address.
module tb_fetch_stage;
    logic Clk;
    logic rst0, rst1;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_if f0 ();
    fetch_if f1 ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) u0 (.Clk(Clk), .Rst(rst0), .fif(f0.slave));
    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u1 (.Clk(Clk), .Rst(rst1), .fif(f1.slave));

    assign f0.ImemInstruction = f0.ImemAddress;
    assign f1.ImemInstruction = f1.ImemAddress;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                        input logic [31:0] pcp4, input logic valid, input logic [31:0] cnt);
        chk({tag, ".addr"},  f0.ImemAddress, addr);
        chk({tag, ".instr"}, f0.IfIdInstruction, instr);
        chk({tag, ".pcp4"},  f0.IfIdPCPlus4, pcp4);
        chk({tag, ".valid"}, {31'b0, f0.IfIdValid}, {31'b0, valid});
        chk({tag, ".count"}, f0.FetchCount, cnt);
    endtask

    task automatic chk1(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                        input logic [31:0] pcp4, input logic valid, input logic [31:0] cnt);
        chk({tag, ".addr"},  f1.ImemAddress, addr);
        chk({tag, ".instr"}, f1.IfIdInstruction, instr);
        chk({tag, ".pcp4"},  f1.IfIdPCPlus4, pcp4);
        chk({tag, ".valid"}, {31'b0, f1.IfIdValid}, {31'b0, valid});
        chk({tag, ".count"}, f1.FetchCount, cnt);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        f0.Stall = 0; f0.Flush = 0; f0.BranchTaken = 0; f0.Jump = 0;
        f0.BranchTarget = 0; f0.JumpTarget = 0;
        f1.Stall = 0; f1.Flush = 0; f1.BranchTaken = 0; f1.Jump = 0;
        f1.BranchTarget = 0; f1.JumpTarget = 0;

        tick(); tick();
        chk0("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        rst0 = 1'b0;
        repeat (4) tick();
        chk0("run4", 32'h10, 32'hC, 32'h10, 1'b1, 32'd4);

        // Mid-run reset, then run to PC = 8.
        rst0 = 1'b1; tick();
        chk0("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst0 = 1'b0; tick(); tick();
        chk0("run2", 32'h8, 32'h4, 32'h8, 1'b1, 32'd2);

        f0.Stall = 1;
        tick(); chk0("stall1", 32'h8, 32'h4, 32'h8, 1'b1, 32'd2);
        tick(); tick();
        chk0("stall3", 32'h8, 32'h4, 32'h8, 1'b1, 32'd2);
        f0.Stall = 0; tick();
        chk0("unstall", 32'hC, 32'h8, 32'hC, 1'b1, 32'd3);
        tick(); tick();
        chk0("to_14", 32'h14, 32'h10, 32'h14, 1'b1, 32'd5);

        f0.BranchTaken = 1; f0.BranchTarget = 32'h40; tick();
        chk0("br", 32'h40, 32'h0, 32'h0, 1'b0, 32'd5);
        f0.BranchTaken = 0; tick();
        chk0("br_next", 32'h44, 32'h40, 32'h44, 1'b1, 32'd6);

        f0.Jump = 1; f0.JumpTarget = 32'h100;
        f0.BranchTaken = 1; f0.BranchTarget = 32'h40; f0.Stall = 1; tick();
        chk0("jmp_br_stall", 32'h100, 32'h0, 32'h0, 1'b0, 32'd6);
        f0.Jump = 0; f0.BranchTaken = 0; f0.Stall = 0; tick();
        chk0("jmp_next", 32'h104, 32'h100, 32'h104, 1'b1, 32'd7);

        // Misaligned target: low bits dropped.
        f0.BranchTaken = 1; f0.BranchTarget = 32'h23; tick();
        chk0("br_align", 32'h20, 32'h0, 32'h0, 1'b0, 32'd7);
        f0.BranchTaken = 0;

        f0.Flush = 1; tick();
        chk0("flush", 32'h24, 32'h0, 32'h0, 1'b0, 32'd7);
        f0.Flush = 0;
        f0.BranchTaken = 1; f0.BranchTarget = 32'h20; tick();
        f0.BranchTaken = 0;
        f0.Flush = 1; f0.Stall = 1; tick();
        chk0("flush_stall", 32'h20, 32'h0, 32'h0, 1'b0, 32'd7);
        f0.Flush = 0; f0.Stall = 0; tick();
        chk0("flush_rel", 32'h24, 32'h20, 32'h24, 1'b1, 32'd8);

        // Non-zero reset PC with address wrap.
        chk1("r1_reset", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 32'd0);
        rst1 = 1'b0; tick();
        chk1("r1_e1", 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1, 32'd1);
        tick();
        chk1("r1_e2", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd2);
        tick();
        chk1("r1_e3", 32'h4, 32'h0, 32'h4, 1'b1, 32'd3);
        rst1 = 1'b1; tick();
        chk1("r1_rst", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
